sw_tile_scheduler: RTL and testbench



---
 rtl/sw_tile_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sw_tile_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_tile_scheduler.sv
// Sequences the Smith-Waterman PE tile datapath: loads R/Q buffers, issues tiles in
// ref-major order, and reduces per-tile maxima into the global best score and position.
module sw_tile_scheduler #(
  parameter int unsigned REF_LEN         = 64,
  parameter int unsigned QRY_LEN         = 48,
  parameter int unsigned PE_DIM          = 4,
  parameter int unsigned WIDTH_SCORE     = 8,
  parameter int unsigned WIDTH_POS_REF   = 7,
  parameter int unsigned WIDTH_POS_QUERY = 6
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ref_we,
  output logic [5:0]                        o_ref_addr,
  output logic                              o_qry_we,
  output logic [5:0]                        o_qry_addr,
  output logic                              o_tile_start,
  output logic [3:0]                        o_tile_i,
  output logic [3:0]                        o_tile_j,
  output logic                              o_init_ref_edge,
  output logic                              o_init_qry_edge,
  input  logic                              i_tile_done,
  input  logic signed [WIDTH_SCORE-1:0]     i_tile_max,
  input  logic [1:0]                        i_tile_off_ref,
  input  logic [1:0]                        i_tile_off_qry,
  output logic                              o_busy,
  output logic                              o_finish,
  output logic signed [WIDTH_SCORE-1:0]     o_max,
  output logic [WIDTH_POS_REF-1:0]          o_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0]        o_pos_query
);

  localparam int unsigned RefCntW = $clog2(REF_LEN + 1);
  localparam int unsigned QryCntW = $clog2(QRY_LEN + 1);
  localparam logic [RefCntW-1:0] RefFull   = RefCntW'(REF_LEN);
  localparam logic [QryCntW-1:0] QryFull   = QryCntW'(QRY_LEN);
  localparam logic [3:0]         TileILast = 4'(REF_LEN / PE_DIM - 1);
  localparam logic [3:0]         TileJLast = 4'(QRY_LEN / PE_DIM - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StAdv,
    StDone
  } state_e;

  state_e                              r_state, w_state_nxt;
  logic [RefCntW-1:0]                  r_ref_cnt, w_ref_cnt_nxt;
  logic [QryCntW-1:0]                  r_qry_cnt, w_qry_cnt_nxt;
  logic [3:0]                          r_tile_i, w_tile_i_nxt;
  logic [3:0]                          r_tile_j, w_tile_j_nxt;
  logic signed [WIDTH_SCORE-1:0]       r_max, w_max_nxt;
  logic [WIDTH_POS_REF-1:0]            r_pos_ref, w_pos_ref_nxt;
  logic [WIDTH_POS_QUERY-1:0]          r_pos_qry, w_pos_qry_nxt;
  logic [WIDTH_POS_REF-1:0]            w_cand_ref;
  logic [WIDTH_POS_QUERY-1:0]          w_cand_qry;

  // 1-based matrix coordinates of the current tile's maximum
  assign w_cand_ref = WIDTH_POS_REF'(r_tile_i) * WIDTH_POS_REF'(PE_DIM)
                    + WIDTH_POS_REF'(i_tile_off_ref) + WIDTH_POS_REF'(1);
  assign w_cand_qry = WIDTH_POS_QUERY'(r_tile_j) * WIDTH_POS_QUERY'(PE_DIM)
                    + WIDTH_POS_QUERY'(i_tile_off_qry) + WIDTH_POS_QUERY'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_ref_cnt <= '0;
      r_qry_cnt <= '0;
      r_tile_i  <= '0;
      r_tile_j  <= '0;
      r_max     <= '0;
      r_pos_ref <= '0;
      r_pos_qry <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ref_cnt <= w_ref_cnt_nxt;
      r_qry_cnt <= w_qry_cnt_nxt;
      r_tile_i  <= w_tile_i_nxt;
      r_tile_j  <= w_tile_j_nxt;
      r_max     <= w_max_nxt;
      r_pos_ref <= w_pos_ref_nxt;
      r_pos_qry <= w_pos_qry_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ref_cnt_nxt = r_ref_cnt;
    w_qry_cnt_nxt = r_qry_cnt;
    w_tile_i_nxt  = r_tile_i;
    w_tile_j_nxt  = r_tile_j;
    w_max_nxt     = r_max;
    w_pos_ref_nxt = r_pos_ref;
    w_pos_qry_nxt = r_pos_qry;
    o_ref_we      = 1'b0;
    o_qry_we      = 1'b0;
    o_tile_start  = 1'b0;
    o_finish      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_valid) begin
          o_ref_we      = 1'b1;
          o_qry_we      = 1'b1;
          w_ref_cnt_nxt = RefCntW'(1);
          w_qry_cnt_nxt = QryCntW'(1);
          w_max_nxt     = '0;
          w_pos_ref_nxt = '0;
          w_pos_qry_nxt = '0;
          w_state_nxt   = StLoad;
        end
      end
      StLoad: begin
        if (i_valid && (r_ref_cnt < RefFull)) begin
          o_ref_we      = 1'b1;
          w_ref_cnt_nxt = r_ref_cnt + RefCntW'(1);
        end
        if (i_valid && (r_qry_cnt < QryFull)) begin
          o_qry_we      = 1'b1;
          w_qry_cnt_nxt = r_qry_cnt + QryCntW'(1);
        end
        // Leave as soon as the final write lands so the first tile follows immediately
        if ((w_ref_cnt_nxt == RefFull) && (w_qry_cnt_nxt == QryFull)) begin
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        o_tile_start = 1'b1;
        w_state_nxt  = StWait;
      end
      StWait: begin
        if (i_tile_done) begin
          if (i_tile_max > r_max) begin
            w_max_nxt     = i_tile_max;
            w_pos_ref_nxt = w_cand_ref;
            w_pos_qry_nxt = w_cand_qry;
          end
          w_state_nxt = StAdv;
        end
      end
      StAdv: begin
        if (r_tile_j != TileJLast) begin
          w_tile_j_nxt = r_tile_j + 4'd1;
          w_state_nxt  = StIssue;
        end else if (r_tile_i != TileILast) begin
          w_tile_j_nxt = '0;
          w_tile_i_nxt = r_tile_i + 4'd1;
          w_state_nxt  = StIssue;
        end else begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_finish      = 1'b1;
        w_ref_cnt_nxt = '0;
        w_qry_cnt_nxt = '0;
        w_tile_i_nxt  = '0;
        w_tile_j_nxt  = '0;
        w_state_nxt   = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_ref_addr      = 6'(r_ref_cnt);
  assign o_qry_addr      = 6'(r_qry_cnt);
  assign o_tile_i        = r_tile_i;
  assign o_tile_j        = r_tile_j;
  assign o_init_ref_edge = ((r_state == StIssue) || (r_state == StWait)) && (r_tile_i == 4'd0);
  assign o_init_qry_edge = ((r_state == StIssue) || (r_state == StWait)) && (r_tile_j == 4'd0);
  assign o_busy          = (r_state != StIdle);
  assign o_max           = r_max;
  assign o_pos_ref       = r_pos_ref;
  assign o_pos_query     = r_pos_qry;

endmodule

// File: tb/tb_sw_tile_scheduler.sv
// Directed bench for sw_tile_scheduler: scoreboard queues for buffer writes and tile order,
// a fixed-latency datapath model, and a reference reduction of the tile maxima.
module tb_sw_tile_scheduler;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid;
  logic              tile_done;
  logic signed [7:0] tile_max;
  logic [1:0]        off_ref, off_qry;
  logic              ref_we, qry_we, tile_start, init_ref_edge, init_qry_edge, busy, finish;
  logic [5:0]        ref_addr, qry_addr;
  logic [3:0]        tile_i, tile_j;
  logic signed [7:0] max_o;
  logic [6:0]        pos_ref;
  logic [5:0]        pos_query;

  int n_chk  = 0;
  int n_pass = 0;
  int q_ref[$];
  int q_qry[$];
  logic [9:0] q_tile[$];

  always #5 clk = ~clk;

  sw_tile_scheduler dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (valid),
    .o_ref_we        (ref_we),
    .o_ref_addr      (ref_addr),
    .o_qry_we        (qry_we),
    .o_qry_addr      (qry_addr),
    .o_tile_start    (tile_start),
    .o_tile_i        (tile_i),
    .o_tile_j        (tile_j),
    .o_init_ref_edge (init_ref_edge),
    .o_init_qry_edge (init_qry_edge),
    .i_tile_done     (tile_done),
    .i_tile_max      (tile_max),
    .i_tile_off_ref  (off_ref),
    .i_tile_off_qry  (off_qry),
    .o_busy          (busy),
    .o_finish        (finish),
    .o_max           (max_o),
    .o_pos_ref       (pos_ref),
    .o_pos_query     (pos_query)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {16'd0, ref_we, qry_we, tile_start, tile_i, tile_j, init_ref_edge, init_qry_edge,
            busy, finish, max_o, pos_ref, pos_query, ref_addr, qry_addr};
  endfunction

  // Datapath response per scenario: 0 = all zero, 1 = tie/negative mix, 2 = single late peak
  function automatic void tile_resp(input int sc, input int i, input int j, output logic [7:0] v,
                                    output logic [1:0] orf, output logic [1:0] oq);
    v   = 8'd0;
    orf = 2'(i);
    oq  = 2'(j);
    if (sc == 1) begin
      if (i == 3 && j == 7) begin v = 8'd9; orf = 2'd2; oq = 2'd1; end
      else if (i == 10 && j == 2) begin v = 8'd9; orf = 2'd0; oq = 2'd0; end
      else if (i == 12 && j == 11) begin v = 8'd5; orf = 2'd3; oq = 2'd3; end
      else if (i == 0 && j == 0) v = 8'hFD;
    end else if (sc == 2) begin
      if (i == 12 && j == 11) begin v = 8'd5; orf = 2'd3; oq = 2'd3; end
    end
  endfunction

  task automatic run(input int sc, input bit gap, input bit spur, input int ab_i, input int ab_j);
    int cyc = 0, sent_ref = 0, sent_qry = 0, pend = 0, spur_cnt = 0;
    int last_ref_cyc = -10, done_cyc = -10, n_start = 0;
    bit loading = 1'b1, finished = 1'b0, aborted = 1'b0, waiting = 1'b0;
    bit spur_now, abort_now = 1'b0, rp, qp;
    logic [9:0] cur = '0, e;
    logic [7:0] v;
    logic [1:0] orf, oq;
    logic signed [7:0] bm = 8'sd0;
    logic [6:0] bpr = '0;
    logic [5:0] bpq = '0;
    q_ref.delete();
    q_qry.delete();
    q_tile.delete();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 12; j++) begin
        q_tile.push_back({4'(i), 4'(j), (i == 0), (j == 0)});
        tile_resp(sc, i, j, v, orf, oq);
        if ($signed(v) > bm) begin
          bm  = v;
          bpr = 7'(i * 4 + int'(orf) + 1);
          bpq = 6'(j * 4 + int'(oq) + 1);
        end
      end
    end
    while (!finished && !aborted && cyc < 4000) begin
      @(posedge clk);
      #1;
      valid = 0; tile_done = 0; tile_max = '0; off_ref = '0; off_qry = '0;
      spur_now = 0; rp = 0; qp = 0;
      if (abort_now) begin
        rst_n = 1'b0;
      end else begin
        if (loading) begin
          valid = !(gap && (cyc % 3 == 2));
          if (valid && sent_ref < 64) begin q_ref.push_back(sent_ref); sent_ref++; rp = 1; end
          if (valid && sent_qry < 48) begin q_qry.push_back(sent_qry); sent_qry++; qp = 1; end
          if (spur && cyc == 10) begin tile_done = 1; tile_max = 8'sd100; end
        end
        if (spur_cnt > 0) begin
          spur_cnt--;
          if (spur_cnt == 0) begin tile_done = 1; tile_max = 8'sd120; spur_now = 1; end
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            tile_resp(sc, int'(cur[9:6]), int'(cur[5:2]), v, orf, oq);
            tile_done = 1; tile_max = v; off_ref = orf; off_qry = oq;
            done_cyc = cyc; waiting = 0;
            if (spur) spur_cnt = 2;
          end
        end
      end
      @(negedge clk);
      if (abort_now) begin
        chk("reset_abort_outs", all_outs(), 64'd0);
        #1 rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        if (cyc == 0) chk("idle_busy_finish", {busy, finish}, 0);
        if (cyc == 1) chk("load_entry_clear", {max_o, pos_ref, pos_query}, 0);
        if (loading) begin
          chk("ref_we", ref_we, rp);
          chk("qry_we", qry_we, qp);
        end
        if (ref_we) begin
          last_ref_cyc = cyc;
          if (q_ref.size() == 0) chk("ref_we_extra", 1, 0);
          else chk("ref_addr", ref_addr, q_ref.pop_front());
        end
        if (qry_we) begin
          if (q_qry.size() == 0) chk("qry_we_extra", 1, 0);
          else chk("qry_addr", qry_addr, q_qry.pop_front());
        end
        if (spur_now && n_start < 192) chk("spur_in_issue", tile_start, 1);
        if (waiting) begin
          chk("wait_hold", {tile_i, tile_j, init_ref_edge, init_qry_edge, busy, tile_start},
              {cur, 1'b1, 1'b0});
        end
        if (tile_start) begin
          loading = 0;
          if (n_start == 0) chk("first_start_lat", cyc, last_ref_cyc + 1);
          else chk("tile_gap", cyc, done_cyc + 2);
          if (q_tile.size() == 0) begin
            chk("tile_extra", 1, 0);
          end else begin
            e = q_tile.pop_front();
            chk("tile_order_edges", {tile_i, tile_j, init_ref_edge, init_qry_edge}, e);
            cur = e;
            if (ab_i >= 0 && int'(e[9:6]) == ab_i && int'(e[5:2]) == ab_j) abort_now = 1;
          end
          n_start++;
          pend = 5;
          waiting = 1;
        end
        if (finish) begin
          chk("res_max", max_o, bm);
          chk("res_pos_ref", pos_ref, bpr);
          chk("res_pos_query", pos_query, bpq);
          chk("tile_count", n_start, 192);
          chk("ref_writes_left", q_ref.size(), 0);
          chk("qry_writes_left", q_qry.size(), 0);
          finished = 1;
        end
      end
      cyc++;
    end
    if (!finished && !aborted) chk("run_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 0; tile_done = 0; tile_max = '0; off_ref = '0; off_qry = '0;
    @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b1, 1'b0, -1, -1);  // gapped load, all-zero sweep
    run(1, 1'b0, 1'b0, -1, -1);  // max reduction with ties and a negative tile
    run(1, 1'b1, 1'b1, -1, -1);  // spurious done in LOAD and ISSUE
    run(1, 1'b0, 1'b0, 6, 4);    // reset while waiting on tile (6,4)
    run(1, 1'b0, 1'b0, -1, -1);  // fresh run after abort
    run(2, 1'b0, 1'b0, -1, -1);  // back-to-back, independent result
    @(negedge clk);
    chk("post_finish_idle", {busy, finish}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
